// File: rtl/spdif_transmitter.sv
// -----------------------------------------------------------------------------
// spdif_transmitter
//   IEC 60958 consumer S/PDIF transmitter. Assembles 192-frame blocks of two
//   32-cell subframes (preamble, 24-bit audio, V/U/C/P) and biphase-mark
//   encodes them onto S_PDIF_Out. Line timing is paced by Cell_Ena, one pulse
//   per half-cell (128 half-cells per frame).
//
// Parameters
//   InputN          sample width (16..24), MSB-aligned to audio bit 27
//   Copy_Permit     channel-status bit 2
//   SampleRate_Code channel-status bits 24..27, bit 24 taken from the code MSB
//
// Ports
//   Clk           system clock
//   nReset        asynchronous active-low reset
//   Cell_Ena      one-Clk strobe per half-cell
//   Active        0: send zero audio with V=1
//   Left, Right   two's complement samples
//   Sample_Valid  latches Left/Right into the holding register
//   S_PDIF_Out    biphase-mark line
//   Frame_Start   pulse when a frame is loaded
//   Block_Start   pulse when frame 0 of a block is loaded
//   Underrun      pulse when a frame is loaded with no new sample pending
// -----------------------------------------------------------------------------
module spdif_transmitter #(
   parameter int         InputN          = 16,
   parameter logic       Copy_Permit     = 1'b1,
   parameter logic [3:0] SampleRate_Code = 4'b0100
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              Cell_Ena,
   input  logic              Active,
   input  logic [InputN-1:0] Left,
   input  logic [InputN-1:0] Right,
   input  logic              Sample_Valid,
   output logic              S_PDIF_Out,
   output logic              Frame_Start,
   output logic              Block_Start,
   output logic              Underrun
);

   // Preamble half-cell patterns for a preceding line level of 0, first
   // half-cell in the MSB.
   localparam logic [7:0] PRE_B = 8'b11101000;
   localparam logic [7:0] PRE_M = 8'b11100010;
   localparam logic [7:0] PRE_W = 8'b11100100;

   logic [6:0]        hc_reg;        // half-cell within frame
   logic [7:0]        fc_reg;        // frame within block
   logic [InputN-1:0] hold_l_reg, hold_r_reg;
   logic [InputN-1:0] last_l_reg, last_r_reg;
   logic              pending_reg;
   logic [63:0]       frame_reg;     // {right subframe, left subframe}
   logic              ref_reg;       // line level just before current subframe

   logic              load;
   logic [InputN-1:0] sel_l, sel_r;
   logic              cs_bit;
   logic [7:0]        pat;
   logic              ref_lvl;
   logic              data_bit;
   logic              out_next;

   assign load  = Cell_Ena && (hc_reg == 7'd0);
   assign sel_l = pending_reg ? hold_l_reg : last_l_reg;
   assign sel_r = pending_reg ? hold_r_reg : last_r_reg;

   // Channel-status bit for the frame being loaded.
   always_comb begin
      cs_bit = 1'b0;
      case (fc_reg)
         8'd2:    cs_bit = Copy_Permit;
         8'd24:   cs_bit = SampleRate_Code[3];
         8'd25:   cs_bit = SampleRate_Code[2];
         8'd26:   cs_bit = SampleRate_Code[1];
         8'd27:   cs_bit = SampleRate_Code[0];
         default: cs_bit = 1'b0;
      endcase
   end

   // One subframe as bit cells 0..31; cells 0..3 are the preamble slot and
   // are never read from here.
   function automatic logic [31:0] make_word(input logic [InputN-1:0] s,
                                             input logic act, input logic c);
      logic [31:0] w;
      logic [23:0] aud;
      aud = 24'(s) << (24 - InputN);
      w = '0;
      if (act) w[27:4] = aud;
      w[28] = ~act;
      w[29] = 1'b0;
      w[30] = c;
      w[31] = ^w[30:4];
      return w;
   endfunction

   // Next line level for the half-cell starting at this Cell_Ena.
   always_comb begin
      out_next = S_PDIF_Out;
      pat      = hc_reg[6] ? PRE_W : ((fc_reg == 8'd0) ? PRE_B : PRE_M);
      // At a subframe boundary the current line level is the reference.
      ref_lvl  = (hc_reg[5:0] == 6'd0) ? S_PDIF_Out : ref_reg;
      data_bit = frame_reg[{hc_reg[6], hc_reg[5:1]}];
      if (hc_reg[5:3] == 3'd0)
         out_next = pat[~hc_reg[2:0]] ^ ref_lvl;
      else if (!hc_reg[0])
         out_next = ~S_PDIF_Out;               // transition at cell start
      else
         out_next = S_PDIF_Out ^ data_bit;     // mid-cell transition for a 1
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         hc_reg      <= '0;
         fc_reg      <= '0;
         hold_l_reg  <= '0;
         hold_r_reg  <= '0;
         last_l_reg  <= '0;
         last_r_reg  <= '0;
         pending_reg <= 1'b0;
         frame_reg   <= '0;
         ref_reg     <= 1'b0;
         S_PDIF_Out  <= 1'b0;
         Frame_Start <= 1'b0;
         Block_Start <= 1'b0;
         Underrun    <= 1'b0;
      end else begin
         Frame_Start <= load;
         Block_Start <= load && (fc_reg == 8'd0);
         Underrun    <= load && !pending_reg;

         if (Cell_Ena) begin
            hc_reg     <= hc_reg + 7'd1;
            S_PDIF_Out <= out_next;
            if (hc_reg[5:0] == 6'd0) ref_reg <= S_PDIF_Out;
            if (hc_reg == 7'd127)
               fc_reg <= (fc_reg == 8'd191) ? 8'd0 : fc_reg + 8'd1;
         end

         if (load) begin
            frame_reg   <= {make_word(sel_r, Active, cs_bit),
                            make_word(sel_l, Active, cs_bit)};
            last_l_reg  <= sel_l;
            last_r_reg  <= sel_r;
            pending_reg <= 1'b0;
         end

         // A sample arriving with the load is kept for the next frame.
         if (Sample_Valid) begin
            hold_l_reg  <= Left;
            hold_r_reg  <= Right;
            pending_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spdif_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spdif_transmitter
//   Drives spdif_transmitter with a Cell_Ena strobe every second Clk, records
//   the line level of every half-cell, decodes each subframe (preamble,
//   biphase-mark bits, cell-start transitions) and compares against a
//   frame-level model of the sample hand-off and subframe contents.
// -----------------------------------------------------------------------------
module tb_spdif_transmitter;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         cell_ena = 1'b0;
   logic         active = 1'b1;
   logic         sample_valid = 1'b0;
   logic [N-1:0] left = '0;
   logic [N-1:0] right = '0;
   logic         s_pdif_out, frame_start, block_start, underrun;

   int total = 0;
   int passed = 0;

   spdif_transmitter #(.InputN(N), .Copy_Permit(1'b1), .SampleRate_Code(4'b0100)) dut (
      .Clk(clk), .nReset(nreset), .Cell_Ena(cell_ena), .Active(active),
      .Left(left), .Right(right), .Sample_Valid(sample_valid),
      .S_PDIF_Out(s_pdif_out), .Frame_Start(frame_start),
      .Block_Start(block_start), .Underrun(underrun));

   always #10 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   // Frame-level model state
   logic [N-1:0] m_hold_l, m_hold_r, m_last_l, m_last_r;
   logic         m_pending;
   int           m_fc;
   logic         prev_level;
   logic         cs_tab [192];

   logic lv [128];
   int   fs_cnt, bs_cnt, ur_cnt;

   typedef struct {
      logic         pre_en;  logic [N-1:0] pre_l;  logic [N-1:0] pre_r;
      logic         load_en; logic [N-1:0] load_l; logic [N-1:0] load_r;
      logic         mid_en;  logic [N-1:0] mid_l;  logic [N-1:0] mid_r;
      logic         act;
   } stim_t;

   typedef struct {
      logic pre_en; logic [N-1:0] l; logic [N-1:0] r; logic act;
      logic [N-1:0] exp_l; logic [N-1:0] exp_r; logic exp_ur;
   } vec_t;

   task automatic check(input string name, input logic [191:0] act_v, input logic [191:0] exp_v);
      total++;
      if (act_v === exp_v) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act_v, exp_v);
   endtask

   function automatic stim_t make_stim(input logic pe, input logic [N-1:0] pl, input logic [N-1:0] pr,
                                       input logic le, input logic [N-1:0] ll, input logic [N-1:0] lr,
                                       input logic me, input logic [N-1:0] ml, input logic [N-1:0] mr,
                                       input logic a);
      stim_t s;
      s.pre_en = pe;  s.pre_l = pl;  s.pre_r = pr;
      s.load_en = le; s.load_l = ll; s.load_r = lr;
      s.mid_en = me;  s.mid_l = ml;  s.mid_r = mr;
      s.act = a;
      return s;
   endfunction

   task automatic model_reset();
      m_hold_l = '0; m_hold_r = '0; m_last_l = '0; m_last_r = '0;
      m_pending = 1'b0; m_fc = 0; prev_level = 1'b0;
   endtask

   task automatic sv_pulse(input logic [N-1:0] l, input logic [N-1:0] r);
      @(negedge clk); sample_valid = 1'b1; left = l; right = r;
      @(negedge clk); sample_valid = 1'b0;
   endtask

   // One half-cell: strobe Cell_Ena for one Clk, then record the line level
   // and pulses in the following Clk.
   task automatic half_cell(input int h, input logic sv, input logic [N-1:0] l, input logic [N-1:0] r);
      @(negedge clk); cell_ena = 1'b1;
      if (sv) begin sample_valid = 1'b1; left = l; right = r; end
      @(negedge clk); cell_ena = 1'b0; sample_valid = 1'b0;
      lv[h] = s_pdif_out;
      fs_cnt += int'(frame_start);
      bs_cnt += int'(block_start);
      ur_cnt += int'(underrun);
   endtask

   // Expected subframe: audio MSB at cell 27, V = !active, C from the
   // channel-status table, P makes cells 4..31 even.
   function automatic logic [31:0] exp_word(input logic [N-1:0] s, input logic a, input int fc);
      logic [31:0] w;
      int ones;
      w = '0;
      ones = 0;
      if (a) for (int i = 0; i < N; i++) w[28 - N + i] = s[i];
      w[28] = !a;
      w[30] = cs_tab[fc];
      for (int i = 4; i <= 30; i++) ones += int'(w[i]);
      w[31] = (ones % 2) == 1;
      return w;
   endfunction

   // Decode a recorded subframe; preamble normalised to preceding level 0.
   function automatic void decode(input int base, input logic ref_l, output logic [7:0] pre,
                                  output logic [31:0] word, output logic tog_ok);
      logic a, b;
      for (int j = 0; j < 8; j++) pre[7 - j] = lv[base + j] ^ ref_l;
      word = '0;
      tog_ok = 1'b1;
      for (int k = 4; k < 32; k++) begin
         a = lv[base + 2 * k];
         b = lv[base + 2 * k + 1];
         if (a == lv[base + 2 * k - 1]) tog_ok = 1'b0;
         word[k] = a ^ b;
      end
   endfunction

   task automatic run_frame(input stim_t st, output logic [N-1:0] got_l, output logic [N-1:0] got_r,
                            output logic got_ur, output logic [7:0] got_pre, output logic c_l, output logic c_r);
      logic [N-1:0] snd_l, snd_r;
      logic         exp_ur;
      int           fc;
      logic [7:0]   pl, pr, exp_pl;
      logic [31:0]  wl, wr, el, er;
      logic         tl, tr;
      active = st.act;
      if (st.pre_en) begin
         sv_pulse(st.pre_l, st.pre_r);
         m_hold_l = st.pre_l; m_hold_r = st.pre_r; m_pending = 1'b1;
      end
      exp_ur = !m_pending;
      snd_l = m_pending ? m_hold_l : m_last_l;
      snd_r = m_pending ? m_hold_r : m_last_r;
      m_last_l = snd_l; m_last_r = snd_r; m_pending = 1'b0;
      if (st.load_en) begin
         m_hold_l = st.load_l; m_hold_r = st.load_r; m_pending = 1'b1;
      end
      fc = m_fc;
      fs_cnt = 0; bs_cnt = 0; ur_cnt = 0;
      for (int h = 0; h < 128; h++) begin
         if (h == 70 && st.mid_en) sv_pulse(st.mid_l, st.mid_r);
         half_cell(h, (h == 0) && st.load_en, st.load_l, st.load_r);
      end
      if (st.mid_en) begin
         m_hold_l = st.mid_l; m_hold_r = st.mid_r; m_pending = 1'b1;
      end
      decode(0, prev_level, pl, wl, tl);
      decode(64, lv[63], pr, wr, tr);
      prev_level = lv[127];
      el = exp_word(snd_l, st.act, fc);
      er = exp_word(snd_r, st.act, fc);
      exp_pl = (fc == 0) ? 8'hE8 : 8'hE2;
      check("frame_start count", 192'(fs_cnt), 192'(1));
      check("block_start count", 192'(bs_cnt), 192'(fc == 0));
      check("underrun count", 192'(ur_cnt), 192'(exp_ur));
      check("left preamble", 192'(pl), 192'(exp_pl));
      check("right preamble", 192'(pr), 192'(8'hE4));
      check("left subframe", 192'(wl[31:4]), 192'(el[31:4]));
      check("right subframe", 192'(wr[31:4]), 192'(er[31:4]));
      check("cell transitions", 192'({tl, tr}), 192'(2'b11));
      $display("frame fc=%0d act=%0d L=%h R=%h underrun=%0d", fc, st.act, wl[27:12], wr[27:12], ur_cnt);
      m_fc = (m_fc + 1) % 192;
      got_l = wl[27:12]; got_r = wr[27:12]; got_ur = (ur_cnt != 0);
      got_pre = pl; c_l = wl[30]; c_r = wr[30];
   endtask

   initial begin
      vec_t         vt [6];
      stim_t        st;
      logic [N-1:0] gl, gr;
      logic         gu, cl, cr;
      logic [7:0]   gp;
      logic [3:0]   code;
      logic [191:0] cs_l, cs_r, cs_exp;
      int           bs_total, fs_total;

      code = 4'b0100;
      for (int i = 0; i < 192; i++) cs_tab[i] = 1'b0;
      cs_tab[2] = 1'b1;
      for (int i = 0; i < 4; i++) cs_tab[24 + i] = code[3 - i];

      vt[0] = '{1'b1, 16'h8001, 16'h0000, 1'b1, 16'h8001, 16'h0000, 1'b0};
      vt[1] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 16'h1234, 16'h5678, 1'b0};
      vt[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h5678, 1'b1};
      vt[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h5678, 1'b1};
      vt[4] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vt[5] = '{1'b1, 16'hFFFF, 16'h8000, 1'b1, 16'hFFFF, 16'h8000, 1'b0};

      model_reset();
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", 192'({s_pdif_out, frame_start, block_start, underrun}), 192'(0));
      nreset = 1'b1;

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         st = make_stim(vt[i].pre_en, vt[i].l, vt[i].r, 1'b0, '0, '0, 1'b0, '0, '0, vt[i].act);
         run_frame(st, gl, gr, gu, gp, cl, cr);
         check("table left audio", 192'(gl), 192'(vt[i].exp_l));
         check("table right audio", 192'(gr), 192'(vt[i].exp_r));
         check("table underrun", 192'(gu), 192'(vt[i].exp_ur));
      end

      // Sample_Valid coincident with the load: 0555 pending, 0AAA arrives with it
      st = make_stim(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 16'h0555, 16'h0555, 1'b1);
      run_frame(st, gl, gr, gu, gp, cl, cr);
      st = make_stim(1'b0, '0, '0, 1'b1, 16'h0AAA, 16'h0AAA, 1'b0, '0, '0, 1'b1);
      run_frame(st, gl, gr, gu, gp, cl, cr);
      check("coincident frame sends old", 192'(gl), 192'(16'h0555));
      check("coincident frame no underrun", 192'(gu), 192'(0));
      st = make_stim(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      run_frame(st, gl, gr, gu, gp, cl, cr);
      check("following frame sends new", 192'(gl), 192'(16'h0AAA));
      check("following frame no underrun", 192'(gu), 192'(0));

      // Reset asserted mid-frame at hc=40
      active = 1'b1;
      for (int h = 0; h <= 40; h++) half_cell(h, 1'b0, '0, '0);
      #3 nreset = 1'b0;
      #1 check("line low in reset", 192'(s_pdif_out), 192'(0));
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      model_reset();

      // Randomised block of 192 frames plus the first frame of the next block
      cs_l = '0; cs_r = '0; bs_total = 0; fs_total = 0;
      for (int f = 0; f <= 192; f++) begin
         st = make_stim(($urandom_range(0, 9) < 8) || (f == 0), N'($urandom), N'($urandom),
                        $urandom_range(0, 9) == 0, N'($urandom), N'($urandom),
                        $urandom_range(0, 9) == 0, N'($urandom), N'($urandom),
                        $urandom_range(0, 9) != 0);
         run_frame(st, gl, gr, gu, gp, cl, cr);
         if (f == 0) check("first preamble after reset", 192'(gp), 192'(8'hE8));
         if (f < 192) begin
            cs_l[f] = cl; cs_r[f] = cr;
            bs_total += bs_cnt; fs_total += fs_cnt;
         end
      end
      cs_exp = '0;
      cs_exp[2] = 1'b1;
      cs_exp[25] = 1'b1;
      check("channel status left", cs_l, cs_exp);
      check("channel status right", cs_r, cs_exp);
      check("block starts per block", 192'(bs_total), 192'(1));
      check("frame starts per block", 192'(fs_total), 192'(192));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/spdif_transmitter.md
Name: spdif_transmitter

Overview:
IEC 60958 consumer S/PDIF transmitter. It is a downstream consumer of the USB audio stage's 48 kHz stereo samples and drives the daughter-board S_PDIF_Out pin. The block assembles 192-frame blocks (B/M/W preambles, 24-bit audio field, V/U/C/P bits) and biphase-mark encodes them. Line timing comes from an external half-cell strobe at 6.144 MHz (128 × 48 kHz), derived from the clock-recovery chain.

Parameters:
InputN, 16, sample width (16..24); MSB-aligned into audio field bit 27, unused LSBs zero.
Copy_Permit, 1, channel-status bit 2.
SampleRate_Code, 4'b0100, channel-status bits 24..27 written in order 24,25,26,27 (48 kHz, i.e. bit 25 = 1).

Ports:
Clk  input  1  system clock (50 MHz).
nReset  input  1  asynchronous active-low reset.
Cell_Ena  input  1  one-Clk pulse per half-cell, 6.144 MHz average rate.
Active  input  1  0: transmit zero audio with V=1; line keeps toggling.
Left  input  InputN  left sample, two's complement.
Right  input  InputN  right sample, two's complement.
Sample_Valid  input  1  one-Clk pulse; latches Left/Right into the holding register.
S_PDIF_Out  output  1  biphase-mark line.
Frame_Start  output  1  one-Clk pulse when a frame is loaded.
Block_Start  output  1  one-Clk pulse when frame 0 is loaded.
Underrun  output  1  one-Clk pulse when a frame is loaded with no new sample pending.

Behaviour:
- Reset (async assert):
  - S_PDIF_Out, Frame_Start, Block_Start and Underrun = 0.
  - Half-cell counter, frame counter, holding register, shift registers, pending flag and last-sample register all = 0.
  - Cleared regardless of phase; no partial frame is completed.
- Counters advance only on Cell_Ena.
  - Half-cell counter hc runs 0..127 and wraps. hc 0..63 is the left subframe, 64..127 the right.
  - Frame counter fc runs 0..191 and increments when hc wraps 127→0.
- Holding register and pending flag:
  - Sample_Valid latches Left/Right into holding and sets pending.
  - A second Sample_Valid before a load overwrites holding (newest wins).
- Frame load occurs on the Cell_Ena with hc==0 (the first Cell_Ena after reset is hc==0).
  - If pending: frame data = holding; pending cleared.
  - Else: frame data = last loaded sample, and Underrun pulses.
  - Sample_Valid in the same Clk as a load: the load uses the old holding value (or repeats last if pending was 0); the new sample is stored with pending=1.
  - Frame_Start pulses on every load; Block_Start additionally pulses when fc==0.
  - Outputs are registered: pulses appear one Clk after the loading Cell_Ena.
- Subframe bit map (bit cells 0..31):
  - Bits 0..3: preamble. B for left when fc==0, M for left otherwise, W for right.
  - Bits 4..27: audio, LSB first. Sample MSB at bit 27; when Active=0 the field is zero.
  - Bit 28: V = ~Active.
  - Bit 29: U = 0.
  - Bit 30: C = channel-status bit fc, identical in both subframes.
  - Bit 31: P = even parity over bits 4..30.
- Channel status (192 bits, consumer format):
  - Bit 2 = Copy_Permit.
  - Bits 24..27 = SampleRate_Code.
  - All other bits 0.
- Preamble half-cell patterns (8 half-cells, given a preceding level of 0):
  - B = 11101000, M = 11100010, W = 11100100.
  - If the preceding level is 1, the pattern is inverted.
- Data encoding: S_PDIF_Out toggles at the start of every data bit cell; it toggles again at mid-cell when the bit is 1.
- Latency: a sample latched ≥1 Clk before the hc==0 Cell_Ena appears starting at that frame. The first preamble half-cell is driven one Clk after that Cell_Ena.
- S_PDIF_Out changes only in the Clk after a Cell_Ena, so the line is glitch-free.
- Because parity is even, every subframe ends at the same line level it started with.

Test Plan:
- Reset release, Active=1, Left=16'h8001, Right=16'h0000, one Sample_Valid, 128 Cell_Ena:
  - decode left subframe: preamble B, bit 12 = 1, bit 27 = 1, V=0, P=0;
  - right subframe: preamble W, all audio bits 0.
- Run 192 frames with Sample_Valid once per frame:
  - Block_Start pulses exactly once per 192 Frame_Start pulses;
  - collected C bits give bit 2 = 1, bit 25 = 1, all others 0;
  - frames 1..191 use M on left.
- Withhold Sample_Valid for 2 frames after loading L=16'h1234:
  - Underrun pulses twice;
  - both frames repeat 16'h1234.
- Active=0 with Left=16'h7FFF:
  - audio field all 0, V=1, P=1 in every subframe;
  - line still toggles at every bit cell.
- Sample_Valid coincident with the hc==0 Cell_Ena carrying 16'h0AAA (prior holding 16'h0555, pending=1):
  - this frame sends 16'h0555;
  - next frame sends 16'h0AAA with no Underrun.
- Assert nReset at hc=40:
  - S_PDIF_Out = 0 immediately;
  - after release, the first output is preamble B pattern 11101000 at fc=0.
